// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: access sizes, FSM states, alignment check.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Size 2'b11 has no legal encoding, so it is reported alongside misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = a[0];
      SIZE_WORD: is_misaligned = (a != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: store data replication/enables and load lane extraction with extension.
// Purely combinational; no flow control.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_a,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_a,
  input  logic        ld_signed,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_a;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = st_a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_a)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_a[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default:   ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage load/store to req/gnt/rvalid bus bridge; read stalls 3 cycles, write 2, at zero bus wait.
// Holds the pipeline via stallM until DONE; bus_req held until bus_gnt or timeout abort.
module dmem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signedM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] mem_data,
  output logic        stallM,
  output logic        misalignM,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t           state_q, state_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [1:0]       a_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             capture;
  logic             op;
  logic             mis;
  logic             expired;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign op      = memreadM | memwriteM;
  assign mis     = is_misaligned(sizeM, addrM[1:0]);
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  lane_align u_lane_align (
    .st_size   (sizeM),
    .st_a      (addrM[1:0]),
    .st_data   (wdataM),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_size   (size_q),
    .ld_a      (a_q),
    .ld_signed (signed_q),
    .ld_raw    (rdata_q),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    stallM    = 1'b0;
    misalignM = 1'b0;
    mem_data  = 32'h0;
    capture   = 1'b0;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmo_d = 1'b0;
        if (op && mis) begin
          misalignM = 1'b1;
        end else if (op) begin
          stallM  = 1'b1;
          capture = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        stallM = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus_gnt) begin
          state_d = we_q ? ST_DONE : ST_WAIT;
        end else if (expired) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        stallM = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = ST_DONE;
        end else if (expired) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        if (!we_q && !tmo_q) mem_data = ld_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset is asynchronous, so the combinational handshakes must drop with it too.
    if (!rst) begin
      stallM    = 1'b0;
      misalignM = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      a_q      <= 2'b00;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      rdata_q  <= 32'h0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      if (capture) begin
        we_q     <= memwriteM;
        addr_q   <= {addrM[31:2], 2'b00};
        a_q      <= addrM[1:0];
        be_q     <= memwriteM ? st_be : 4'b1111;
        wdata_q  <= memwriteM ? st_wdata : 32'h0;
        size_q   <= sizeM;
        signed_q <= signedM;
      end
    end
  end

  assign bus_req   = (state_q == ST_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, misalignment, gnt delay, timeout, reset abort.
module tb_dmem_access_unit;

  logic        clk, rst;
  logic        memreadM, memwriteM, signedM;
  logic [1:0]  sizeM;
  logic [31:0] addrM, wdataM;
  logic [31:0] mem_data;
  logic        stallM, misalignM, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  int          stall_cnt, req_cnt;
  logic        done_seen, stable, got_err, rwe;
  logic [31:0] got_data, ra, rwd;
  logic [3:0]  rbe;

  dmem_access_unit #(.TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .signedM(signedM),
    .addrM(addrM), .wdataM(wdataM), .mem_data(mem_data), .stallM(stallM),
    .misalignM(misalignM), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access from IDLE and plays the bus slave; starts and ends 1 time unit after a rising edge.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_delay, input logic [31:0] rd, input int max_cyc);
    logic rv_pending;
    memreadM = !we; memwriteM = we; sizeM = sz; signedM = sg; addrM = addr; wdataM = wd;
    stall_cnt = 0; req_cnt = 0; done_seen = 1'b0; stable = 1'b1;
    got_data = 32'h0; got_err = 1'b0; rv_pending = 1'b0;
    ra = 32'h0; rbe = 4'h0; rwd = 32'h0; rwe = 1'b0;
    for (int c = 0; c < max_cyc && !done_seen; c++) begin
      bus_gnt    = (bus_req === 1'b1) && (req_cnt == gnt_delay);
      bus_rvalid = rv_pending;
      bus_rdata  = rv_pending ? rd : 32'h0;
      rv_pending = bus_gnt && !we;
      @(negedge clk);
      if (bus_req === 1'b1) begin
        if (req_cnt == 0) begin
          ra = bus_addr; rbe = bus_be; rwd = bus_wdata; rwe = bus_we;
        end else if (bus_addr !== ra || bus_be !== rbe || bus_wdata !== rwd) begin
          stable = 1'b0;
        end
        req_cnt++;
      end
      if (stallM === 1'b1) stall_cnt++;
      else if (stall_cnt > 0) begin
        done_seen = 1'b1; got_data = mem_data; got_err = bus_err;
      end
      @(posedge clk); #1;
    end
    memreadM = 1'b0; memwriteM = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b0; memreadM = 0; memwriteM = 0; sizeM = 0; signedM = 0; addrM = 0; wdataM = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stallM); end
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus_req); end
    n_cmp++; if (misalignM !== 1'b0) begin n_err++; $display("FAIL rst_mis got %b want 0", misalignM); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", bus_err); end
    n_cmp++; if (mem_data !== 32'h0) begin n_err++; $display("FAIL rst_mem_data got %h want 0", mem_data); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin
      n_err++; $display("FAIL rst_bus got we=%b be=%b addr=%h wd=%h want 0", bus_we, bus_be, bus_addr, bus_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 20);
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL lw_done got %b want 1", done_seen); end
    n_cmp++; if (stall_cnt != 3) begin n_err++; $display("FAIL lw_stall got %0d want 3", stall_cnt); end
    n_cmp++; if (got_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", got_data); end
    n_cmp++; if ({rwe, rbe, ra} !== {1'b0, 4'b1111, 32'h100}) begin
      n_err++; $display("FAIL lw_bus got we=%b be=%b addr=%h want we=0 be=1111 addr=100", rwe, rbe, ra);
    end
  endtask

  task automatic test_sb;
    run_access(1'b1, 2'b00, 1'b0, 32'h103, 32'h12345678, 0, 32'h0, 20);
    n_cmp++; if (stall_cnt != 2) begin n_err++; $display("FAIL sb_stall got %0d want 2", stall_cnt); end
    n_cmp++; if (ra !== 32'h100) begin n_err++; $display("FAIL sb_addr got %h want 100", ra); end
    n_cmp++; if (rbe !== 4'b1000) begin n_err++; $display("FAIL sb_be got %b want 1000", rbe); end
    n_cmp++; if (rwd !== 32'h78787878) begin n_err++; $display("FAIL sb_wdata got %h want 78787878", rwd); end
    n_cmp++; if (rwe !== 1'b1) begin n_err++; $display("FAIL sb_we got %b want 1", rwe); end
    n_cmp++; if (got_data !== 32'h0) begin n_err++; $display("FAIL sb_mem_data got %h want 0", got_data); end
    run_access(1'b1, 2'b01, 1'b0, 32'h102, 32'hAAAA5555, 0, 32'h0, 20);
    n_cmp++; if ({rbe, rwd} !== {4'b1100, 32'h55555555}) begin
      n_err++; $display("FAIL sh_lanes got be=%b wd=%h want be=1100 wd=55555555", rbe, rwd);
    end
  endtask

  task automatic test_load_ext;
    run_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h80010000, 20);
    n_cmp++; if (got_data !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_signed got %h want ffff8001", got_data); end
    run_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 32'h80010000, 20);
    n_cmp++; if (got_data !== 32'h00008001) begin n_err++; $display("FAIL lhu got %h want 00008001", got_data); end
    run_access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 32'h00008000, 20);
    n_cmp++; if (got_data !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_signed got %h want ffffff80", got_data); end
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h9A000000, 20);
    n_cmp++; if (got_data !== 32'h0000009A) begin n_err++; $display("FAIL lbu got %h want 0000009a", got_data); end
  endtask

  task automatic test_misalign;
    memreadM = 1'b1; sizeM = 2'b10; addrM = 32'h102;
    @(negedge clk);
    n_cmp++; if ({misalignM, stallM, bus_req} !== 3'b100) begin
      n_err++; $display("FAIL lw_mis got mis=%b stall=%b req=%b want 1 0 0", misalignM, stallM, bus_req);
    end
    n_cmp++; if (mem_data !== 32'h0) begin n_err++; $display("FAIL lw_mis_data got %h want 0", mem_data); end
    @(posedge clk); #1; memreadM = 1'b0;
    @(negedge clk);
    n_cmp++; if ({misalignM, stallM, bus_req} !== 3'b000) begin
      n_err++; $display("FAIL mis_pulse got mis=%b stall=%b req=%b want 0 0 0", misalignM, stallM, bus_req);
    end
    @(posedge clk); #1; memwriteM = 1'b1; sizeM = 2'b11; addrM = 32'h100;
    @(negedge clk);
    n_cmp++; if ({misalignM, stallM} !== 2'b10) begin
      n_err++; $display("FAIL size11_mis got mis=%b stall=%b want 1 0", misalignM, stallM);
    end
    @(posedge clk); #1; memwriteM = 1'b0; memreadM = 1'b1; sizeM = 2'b01; addrM = 32'h101;
    @(negedge clk);
    n_cmp++; if ({misalignM, stallM} !== 2'b10) begin
      n_err++; $display("FAIL lh_odd_mis got mis=%b stall=%b want 1 0", misalignM, stallM);
    end
    @(posedge clk); #1; memreadM = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL mis_no_req got %b want 0", bus_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_gnt_delay;
    run_access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 3, 32'h0BADF00D, 30);
    n_cmp++; if (req_cnt != 4) begin n_err++; $display("FAIL gd_req_cycles got %0d want 4", req_cnt); end
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL gd_stable got %b want 1", stable); end
    n_cmp++; if (stall_cnt != 6) begin n_err++; $display("FAIL gd_stall got %0d want 6", stall_cnt); end
    n_cmp++; if (got_data !== 32'h0BADF00D) begin n_err++; $display("FAIL gd_data got %h want 0badf00d", got_data); end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 100000, 32'h11111111, 400);
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL tmo_done got %b want 1", done_seen); end
    n_cmp++; if (req_cnt != 255) begin n_err++; $display("FAIL tmo_req_cycles got %0d want 255", req_cnt); end
    n_cmp++; if (stall_cnt != 256) begin n_err++; $display("FAIL tmo_stall got %0d want 256", stall_cnt); end
    n_cmp++; if ({got_err, got_data} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL tmo_err_data got err=%b data=%h want err=1 data=0", got_err, got_data);
    end
    run_access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0, 32'h55AA55AA, 20);
    n_cmp++; if ({bus_err, got_data} !== {1'b1, 32'h55AA55AA}) begin
      n_err++; $display("FAIL tmo_sticky got err=%b data=%h want err=1 data=55aa55aa", bus_err, got_data);
    end
  endtask

  task automatic test_reset_wait;
    memreadM = 1'b1; sizeM = 2'b10; signedM = 1'b0; addrM = 32'h300;
    @(posedge clk); #1; bus_gnt = 1'b1;
    @(posedge clk); #1; bus_gnt = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus_req, stallM} !== 2'b00) begin
      n_err++; $display("FAIL rstw_abort got req=%b stall=%b want 0 0", bus_req, stallM);
    end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rstw_err_clr got %b want 0", bus_err); end
    @(posedge clk); #1; memreadM = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'hCAFEF00D, 20);
    n_cmp++; if (stall_cnt != 3) begin n_err++; $display("FAIL rstw_restart_stall got %0d want 3", stall_cnt); end
    n_cmp++; if ({got_err, got_data} !== {1'b0, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL rstw_restart got err=%b data=%h want err=0 data=cafef00d", got_err, got_data);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_load_ext();
    test_misalign();
    test_gnt_delay();
    test_timeout();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, want completion before 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
